// File: rtl/dmem_access_unit.sv
// Data-memory initiator: one load/store at a time, loads return on resp channel READ_LATENCY+2 cycles after accept.
// Backpressure: req_ready only in IDLE; a load result is held in RESP until resp_ready.
module dmem_access_unit #(
    parameter int ADDR_WIDTH   = 18,
    parameter int READ_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        addr_error,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    output logic        mem_distinct,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [1:0] {IDLE, STORE, LOAD_WAIT, RESP} state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        resp_valid_q, resp_valid_d;
    logic        addr_error_q, addr_error_d;
    logic        mem_we_q, mem_we_d;
    logic        mem_re_q, mem_re_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        in_range;

    assign in_range = ((req_addr >> ADDR_WIDTH) == 32'd0);

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            resp_valid_q <= 1'b0;
            addr_error_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            resp_data_q  <= 32'd0;
            resp_rd_q    <= 5'd0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            addr_error_q <= addr_error_d;
            mem_we_q     <= mem_we_d;
            mem_re_q     <= mem_re_d;
            resp_data_q  <= resp_data_d;
            resp_rd_q    <= resp_rd_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        addr_error_d = 1'b0;
        mem_we_d     = 1'b0;
        mem_re_d     = 1'b0;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!in_range) begin
                        // Out-of-range: no memory access; loads still complete with zero data.
                        addr_error_d = 1'b1;
                        if (!req_write) begin
                            state_d      = RESP;
                            resp_valid_d = 1'b1;
                            resp_data_d  = 32'd0;
                            resp_rd_d    = req_rd;
                        end
                    end else if (req_write) begin
                        state_d     = STORE;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = req_addr;
                        mem_wdata_d = req_wdata;
                    end else begin
                        state_d    = LOAD_WAIT;
                        mem_re_d   = 1'b1;
                        mem_addr_d = req_addr;
                        resp_rd_d  = req_rd;
                        cnt_d      = 2'(READ_LATENCY);
                    end
                end
            end
            STORE: begin
                state_d = IDLE;
            end
            LOAD_WAIT: begin
                // MemRead stays high for READ_LATENCY+1 cycles; capture data on the last one.
                if (cnt_q == 2'd0) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem_read_data;
                end else begin
                    cnt_d    = cnt_q - 2'd1;
                    mem_re_d = 1'b1;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready      = (state_q == IDLE);
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_rd        = resp_rd_q;
    assign addr_error     = addr_error_q;
    assign mem_address    = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_MemWrite   = mem_we_q;
    assign mem_MemRead    = mem_re_q;
    assign mem_distinct   = mem_we_q;

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator side of the data-memory interface: accepts load/store requests from the execute stage on a valid/ready handshake.
- Drives address, write data, MemWrite, MemRead and distinct into data_memory.
- Waits out the block-RAM read latency, then returns load data with its destination-register tag on a valid/ready response channel.
- Sits between the core's execute/writeback stages and data_memory.

Parameters:
- ADDR_WIDTH, 18, number of word-address bits implemented by data memory; addresses with any bit set above this are out of range.
- READ_LATENCY, 1, clock edges from an enabled BRAM read to valid mem_read_data (1 or 2).

Ports:
- CLK  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept a request this cycle.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  word address.
- req_wdata  input  32  store data.
- req_rd  input  5  load destination register tag.
- resp_valid  output  1  load result valid.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  32  load result.
- resp_rd  output  5  tag echoed from the request.
- addr_error  output  1  one-cycle pulse: out-of-range request accepted.
- mem_address  output  32  to data_memory address.
- mem_write_data  output  32  to data_memory write_data.
- mem_MemWrite  output  1  to data_memory MemWrite.
- mem_MemRead  output  1  to data_memory MemRead.
- mem_distinct  output  1  to data_memory distinct.
- mem_read_data  input  32  from data_memory read_data.

Behaviour:
- States: IDLE, STORE, LOAD_WAIT, RESP.
- req_ready = (state == IDLE), combinational. Requests are accepted only on req_valid & req_ready.
- All other outputs are registered.
- Reset (async, while low): state IDLE; resp_valid, addr_error, mem_MemWrite, mem_MemRead, mem_distinct = 0; resp_data, resp_rd, mem_address, mem_write_data = 0; req_ready = 1.
- Range check: in range iff req_addr[31:ADDR_WIDTH] == 0.
- Out-of-range accept:
  - addr_error = 1 for the next cycle only; no memory access is issued.
  - Load: go to RESP with resp_data = 0 and resp_rd = req_rd.
  - Store: stay in IDLE; the store is dropped.
- In-range store accept:
  - Register address and data, go to STORE.
  - STORE lasts exactly 1 cycle with mem_MemWrite = mem_distinct = 1 and mem_MemRead = 0, then IDLE.
  - Store throughput: 1 per 2 cycles. Stores produce no response.
- In-range load accept:
  - Register address and tag, go to LOAD_WAIT.
  - LOAD_WAIT lasts READ_LATENCY+1 cycles, tracked by a down-counter.
  - mem_MemRead = 1 and mem_address held stable throughout LOAD_WAIT.
  - On the edge ending the last LOAD_WAIT cycle: resp_data <= mem_read_data, go to RESP.
  - resp_valid rises READ_LATENCY+2 cycles after the acceptance cycle.
- RESP:
  - resp_valid = 1; resp_data and resp_rd held stable until resp_ready.
  - On resp_valid & resp_ready: next state IDLE, resp_valid = 0.
  - With resp_ready held high, RESP lasts exactly 1 cycle.
- Invariants:
  - mem_MemWrite and mem_MemRead are never both 1.
  - mem_distinct == mem_MemWrite always, so each store writes exactly once.
  - mem_MemRead and mem_MemWrite are 0 in IDLE and RESP.
- req_valid in non-IDLE states is ignored; the requester must hold the request until it is accepted.
- Reset asserted mid-operation: immediate return to reset values. An in-flight STORE write is suppressed, and a pending load response is discarded.
- No overlap between requests: a new request is accepted only after the previous one completes.

Test Plan:
- Reset, then store addr 0x10, data 0xDEADBEEF -> exactly one cycle after acceptance: mem_MemWrite = mem_distinct = 1, mem_address = 0x10, mem_write_data = 0xDEADBEEF, req_ready = 0; IDLE the cycle after.
- Load addr 0x10, req_rd = 7, READ_LATENCY = 1, BRAM model holding 0xDEADBEEF -> mem_MemRead = 1 for 2 cycles; resp_valid 3 cycles after acceptance with resp_data = 0xDEADBEEF, resp_rd = 7; never any MemWrite.
- Load completes with resp_ready low for 4 cycles -> resp_valid, resp_data, resp_rd stable; req_ready = 0; mem_MemRead = 0; resp_ready high -> IDLE next cycle.
- Store then load addr 0x0004_0000 (ADDR_WIDTH = 18) -> each gives an addr_error pulse of exactly 1 cycle; no MemWrite or MemRead; the load gives resp_data = 0 the cycle after acceptance.
- reset driven low in the 2nd LOAD_WAIT cycle -> mem_MemRead and resp_valid go to 0 without waiting for a clock edge; after release, req_ready = 1 and no response appears.
- READ_LATENCY = 2: store 0x3 -> 0x12345678, then load 0x3 back-to-back -> resp_data = 0x12345678 exactly 4 cycles after load acceptance.
